// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed seven-segment scanner:
//   scan_state_e : the two slot phases, GUARD (anodes off) and SHOW
//   SEG_OFF      : all eight segments dark (active-low)
//   DECODE_LUT   : hex nibble -> active-low gfedcba pattern, index = nibble
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry 15 (F) is leftmost, entry 0 is rightmost.
  localparam logic [15:0][6:0] DECODE_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nib : in  [3:0] hex digit
//   seg : out [6:0] active-low gfedcba pattern
// ---------------------------------------------------------------------------
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = DECODE_LUT[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// N-digit time-multiplexed seven-segment scanner. A hex word with per-digit
// enables and decimal points is captured into a shadow register on load; the
// scanner walks the digits, one slot of CLK_HZ/SCAN_HZ clocks each, keeping
// all anodes off for the first GUARD_CYC clocks of every slot (anti-ghosting).
//
// Optional feature: define ZERO_BLANK_EN for leading-zero suppression
// (a digit above digit 0 goes dark when it and all higher nibbles are zero
// and its decimal point is off). The suppression mask is folded into the
// shadow enables at load time.
//
// Ports:
//   clk  : in  system clock
//   rst  : in  asynchronous reset, active-low
//   hex  : in  [4*DIGITS-1:0] nibble i feeds digit i (digit 0 rightmost)
//   en   : in  [DIGITS-1:0]   per-digit enable, 0 = dark
//   dp   : in  [DIGITS-1:0]   per-digit decimal point, 1 = lit
//   load : in  capture hex/en/dp into the shadow register
//   SEG  : out [7:0]          active-low segments, [7]=dp, [6:0]=gfedcba
//   AN   : out [DIGITS-1:0]   active-low anodes, at most one low
// ---------------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int GUARD_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     en,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN
);

  localparam int TICK  = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] shadow_hex_p0;
  logic [DIGITS-1:0]      shadow_en_p0;
  logic [DIGITS-1:0]      shadow_dp_p0;
  logic [DIGITS-1:0]      en_eff;

  logic [CNT_W-1:0]       cnt_p0;
  logic [IDX_W-1:0]       idx_p0;
  scan_state_e            state_p0;

  logic [3:0]             cur_nib;
  logic [6:0]             cur_seg;
  logic                   cur_lit;

  logic [7:0]             seg_p1;
  logic [DIGITS-1:0]      an_p1;

`ifdef ZERO_BLANK_EN
  // Marks digits 1..DIGITS-1 that are leading zeros without a decimal point.
  function automatic logic [DIGITS-1:0] lead_zero_mask(
    input logic [4*DIGITS-1:0] h,
    input logic [DIGITS-1:0]   d
  );
    logic [DIGITS-1:0] m;
    logic              higher_zero;
    m           = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (higher_zero && (h[4*i +: 4] == 4'h0) && !d[i])
        m[i] = 1'b1;
      higher_zero = higher_zero && (h[4*i +: 4] == 4'h0);
    end
    return m;
  endfunction

  assign en_eff = en & ~lead_zero_mask(hex, dp);
`else
  assign en_eff = en;
`endif

  // ---- stage p0: shadow register, prescaler, digit index, slot phase ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_hex_p0 <= '0;
      shadow_en_p0  <= '0;
      shadow_dp_p0  <= '0;
    end else if (load) begin
      shadow_hex_p0 <= hex;
      shadow_en_p0  <= en_eff;
      shadow_dp_p0  <= dp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p0   <= '0;
      idx_p0   <= '0;
      state_p0 <= GUARD;
    end else if (cnt_p0 == CNT_LAST) begin
      cnt_p0   <= '0;
      idx_p0   <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      state_p0 <= GUARD;
    end else begin
      cnt_p0   <= cnt_p0 + 1'b1;
      // The phase tracks the count it is about to take.
      state_p0 <= (cnt_p0 >= GUARD_LAST) ? SHOW : GUARD;
    end
  end

  assign cur_nib = shadow_hex_p0[idx_p0];
  assign cur_lit = (state_p0 == SHOW) && shadow_en_p0[idx_p0];

  seg7_decode u_decode (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // ---- stage p1: registered segment and anode drive ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_p1 <= SEG_OFF;
      an_p1  <= '1;
    end else if (cur_lit) begin
      seg_p1 <= {~shadow_dp_p0[idx_p0], cur_seg};
      an_p1  <= ~(DIGITS'(1) << idx_p0);
    end else begin
      seg_p1 <= SEG_OFF;
      an_p1  <= '1;
    end
  end

  assign SEG = seg_p1;
  assign AN  = an_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
// Scoreboard bench for seg_scan_driver (DIGITS=4, TICK=10, GUARD_CYC=2).
// The stimulus process advances one clock at a time and pushes the expected
// AN/SEG for that clock, derived from the elapsed cycle count since reset and
// the loaded word; a monitor pops and compares one entry after every edge.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int DIGITS    = 4;
  localparam int CLK_HZ    = 1000;
  localparam int SCAN_HZ   = 100;
  localparam int GUARD_CYC = 2;
  localparam int TICK      = CLK_HZ / SCAN_HZ;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] hex  = '0;
  logic [3:0]  en   = '0;
  logic [3:0]  dp   = '0;
  logic        load = 1'b0;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  seg_scan_driver #(
    .DIGITS    (DIGITS),
    .CLK_HZ    (CLK_HZ),
    .SCAN_HZ   (SCAN_HZ),
    .GUARD_CYC (GUARD_CYC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .hex  (hex),
    .en   (en),
    .dp   (dp),
    .load (load),
    .SEG  (SEG),
    .AN   (AN)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: loaded word and edges since reset release.
  logic [15:0] m_hex = '0;
  logic [3:0]  m_en  = '0;
  logic [3:0]  m_dp  = '0;
  int          k     = 0;

  // Display patterns with the decimal point off, indexed by hex value.
  logic [7:0] seg_tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Expected outputs after the kk-th edge since reset release.
  function automatic exp_t model_out(input int kk);
    exp_t e;
    int   c;
    int   d;
    bit   lit;
    e.an  = 4'hF;
    e.seg = 8'hFF;
    if (kk < 1) return e;
    c   = (kk - 1) % TICK;
    d   = ((kk - 1) / TICK) % DIGITS;
    lit = m_en[d];
`ifdef ZERO_BLANK_EN
    if (d != 0 && !m_dp[d] && ((m_hex >> (4 * d)) == 16'h0)) lit = 1'b0;
`endif
    if (c >= GUARD_CYC && lit) begin
      e.an  = ~(4'b0001 << d);
      e.seg = seg_tbl[m_hex[4*d +: 4]];
      if (m_dp[d]) e.seg[7] = 1'b0;
    end
    return e;
  endfunction

  // One clock edge: compute what the DUT must show after it, then apply load.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    if (!rst) begin
      k     = 0;
      m_hex = '0;
      m_en  = '0;
      m_dp  = '0;
      e.an  = 4'hF;
      e.seg = 8'hFF;
    end else begin
      k++;
      e = model_out(k);
      if (load) begin
        m_hex = hex;
        m_en  = en;
        m_dp  = dp;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    load = 1'b0;
    cycle();
  endtask

  task automatic tick_load(input logic [15:0] h, input logic [3:0] e, input logic [3:0] d);
    @(negedge clk);
    hex  = h;
    en   = e;
    dp   = d;
    load = 1'b1;
    cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Load exactly on a slot-boundary edge.
  task automatic boundary_load(input logic [15:0] h, input logic [3:0] e, input logic [3:0] d);
    while (((k + 1) % TICK) != 0) tick();
    tick_load(h, e, d);
  endtask

  task automatic check_now(input string name, input logic [3:0] an_req, input logic [7:0] seg_req);
    vectors++;
    if (AN !== an_req || SEG !== seg_req) begin
      miscompares++;
      $display("FAIL %s: AN=%b SEG=%h, required AN=%b SEG=%h", name, AN, SEG, an_req, seg_req);
    end
  endtask

  // Monitor: one comparison per edge, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (AN !== e.an || SEG !== e.seg) begin
          miscompares++;
          $display("FAIL scan k=%0d t=%0t: AN=%b SEG=%h, required AN=%b SEG=%h",
                   k, $time, AN, SEG, e.an, e.seg);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t probe;
    bit   found;

    // Reset state, asserted asynchronously before any clock edge.
    #1 rst = 1'b0;
    #1 check_now("reset_async", 4'hF, 8'hFF);
    run(3);
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    cycle();

    // Empty shadow: every digit dark.
    run(2 * TICK);

    // "1234", all digits on, no decimal points; a full wrap and a bit more.
    boundary_load(16'h1234, 4'hF, 4'h0);
    run(5 * TICK);

    // Per-digit enables and decimal point.
    boundary_load(16'h1234, 4'b1010, 4'b0010);
    run(4 * TICK);

    // Leading zeros, then all zeros.
    boundary_load(16'h0050, 4'hF, 4'h0);
    run(4 * TICK);
    boundary_load(16'h0000, 4'hF, 4'h0);
    run(4 * TICK);

    // Randomized words, enables and points.
    for (int r = 0; r < 20; r++) begin
      boundary_load(16'($urandom), 4'($urandom), 4'($urandom));
      run($urandom_range(TICK, 5 * TICK));
    end

    // Reset pulse during the digit-2 SHOW phase.
    boundary_load(16'h1234, 4'hF, 4'($urandom));
    found = 1'b0;
    for (int i = 0; i < 8 * TICK && !found; i++) begin
      tick();
      probe = model_out(k);
      if (probe.an == 4'b1011) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL digit2_search: reached=%0d required=1", found);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 check_now("reset_mid_show", 4'hF, 8'hFF);
    cycle();
    run(2);
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    cycle();
    // Shadow was cleared by reset; reload and watch the restart from digit 0.
    run(TICK - 1);
    boundary_load(16'hABCD, 4'hF, 4'b0101);
    run(5 * TICK);

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: pending=%0d required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
